// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU result, branch/move condition, condition codes,
// sticky processor status and retired-instruction counter.
module execute_stage #(
    parameter logic [2:0] CC_RESET = 3'b100,
    parameter int         CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [63:0]      valA,
    input  logic [63:0]      valB,
    input  logic [63:0]      valC,
    output logic [63:0]      valE,
    output logic             Cnd,
    output logic             ZF,
    output logic             SF,
    output logic             OF,
    output logic [2:0]       stat,
    output logic [CNT_W-1:0] inst_count
);

    typedef enum logic [2:0] {
        AOK = 3'd1,
        HLT = 3'd2,
        INS = 3'd4
    } stat_t;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    stat_t state;

    function automatic logic [63:0] alu(input logic [3:0] ic, input logic [3:0] fn,
                                        input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] c);
        logic [63:0] r;
        r = 64'd0;
        case (ic)
            I_RRMOVQ:          r = a;
            I_IRMOVQ:          r = c;
            I_RMMOVQ, I_MRMOVQ: r = b + c;
            I_OPQ: begin
                case (fn)
                    4'd0:    r = b + a;
                    4'd1:    r = b - a;
                    4'd2:    r = b & a;
                    4'd3:    r = b ^ a;
                    default: r = 64'd0;
                endcase
            end
            I_CALL, I_PUSHQ:   r = b - 64'd8;
            I_RET, I_POPQ:     r = b + 64'd8;
            default:           r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic cond(input logic [3:0] fn, input logic zf,
                                  input logic sf, input logic of);
        logic c;
        c = 1'b0;
        case (fn)
            4'd0:    c = 1'b1;
            4'd1:    c = (sf ^ of) | zf;
            4'd2:    c = sf ^ of;
            4'd3:    c = zf;
            4'd4:    c = ~zf;
            4'd5:    c = ~(sf ^ of);
            4'd6:    c = ~(sf ^ of) & ~zf;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    logic halt_req;
    logic invalid;
    logic of_next;

    always_comb begin
        valE = alu(icode, ifun, valA, valB, valC);
        Cnd  = (icode == I_RRMOVQ || icode == I_JXX) ? cond(ifun, ZF, SF, OF) : 1'b0;
    end

    always_comb begin
        halt_req = (icode == I_HALT);
        invalid  = (icode > I_POPQ)
                || (icode == I_OPQ && ifun > 4'd3)
                || ((icode == I_RRMOVQ || icode == I_JXX) && ifun > 4'd6);
        case (ifun)
            4'd0:    of_next = (valA[63] == valB[63]) && (valE[63] != valB[63]);
            4'd1:    of_next = (valA[63] != valB[63]) && (valE[63] != valB[63]);
            default: of_next = 1'b0;
        endcase
    end

    // Status and CC state; HLT/INS freeze everything until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= AOK;
            {ZF, SF, OF} <= CC_RESET;
            inst_count   <= '0;
        end else if (state == AOK) begin
            if (halt_req) begin
                state <= HLT;
            end else if (invalid) begin
                state <= INS;
            end else begin
                inst_count <= inst_count + 1'b1;
                if (icode == I_OPQ) begin
                    ZF <= (valE == 64'd0);
                    SF <= valE[63];
                    OF <= of_next;
                end
            end
        end
    end

    assign stat = state;

endmodule
